branch_predictor: RTL and testbench

- Dynamic branch predictor for the RISC-V core: a direct-mapped branch history table (BHT) of 2-bit saturating counters plus a branch target buffer (BTB).
- Fetch looks up the current PC combinationally and receives a predicted direction and target.
- Execute writes back the resolved outcome; this is the taken/not-taken result produced by the branch comparison logic.
- The block also flags mispredictions with a registered redirect and keeps performance counters.

---
 rtl/branch_predictor_if.sv | 40 ++++
 rtl/branch_predictor.sv | 151 +++++++++++++++
 tb/tb_branch_predictor.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-update bundle of the branch predictor.
interface branch_predictor_if;
    // Fetch-side lookup
    logic [31:0] fetch_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;

    // Execute-side resolution
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;

    // Redirect and performance counters
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    // Pipeline side: drives PCs and resolutions, consumes predictions
    modport master (
        output fetch_pc,
        output upd_valid, upd_pc, upd_taken, upd_target,
        output upd_pred_taken, upd_pred_target,
        input  pred_hit, pred_taken, pred_target,
        input  mispredict, redirect_pc, branch_count, mispredict_count
    );

    // Predictor side
    modport slave (
        input  fetch_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target,
        input  upd_pred_taken, upd_pred_target,
        output pred_hit, pred_taken, pred_target,
        output mispredict, redirect_pc, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BHT (2-bit saturating counters) + BTB with registered
// mispredict redirect and branch/mispredict performance counters.
module branch_predictor #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bp
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Table storage
    logic              valid_q  [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];

    // Single-entry write port, driven by the update logic
    logic              ent_we;
    logic              ent_valid_d;
    logic [1:0]        ent_ctr_d;
    logic [TAG_W-1:0]  ent_tag_d;
    logic [31:0]       ent_target_d;

    logic              mispredict_q,       mispredict_d;
    logic [31:0]       redirect_q,         redirect_d;
    logic [31:0]       branch_cnt_q,       branch_cnt_d;
    logic [31:0]       mis_cnt_q,          mis_cnt_d;

    logic [IDX_W-1:0]  f_idx;
    logic [TAG_W-1:0]  f_tag;
    logic [IDX_W-1:0]  u_idx;
    logic [TAG_W-1:0]  u_tag;
    logic              u_hit;
    logic              mis_c;

    assign f_idx = bp.fetch_pc[IDX_W+1:2];
    assign f_tag = bp.fetch_pc[31:IDX_W+2];
    assign u_idx = bp.upd_pc[IDX_W+1:2];
    assign u_tag = bp.upd_pc[31:IDX_W+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // Zero-latency lookup from pre-update table state (no bypass)
    always_comb begin
        bp.pred_hit    = 1'b0;
        bp.pred_taken  = 1'b0;
        bp.pred_target = bp.fetch_pc + 32'd4;
        if (valid_q[f_idx] && (tag_q[f_idx] == f_tag)) begin
            bp.pred_hit   = 1'b1;
            bp.pred_taken = ctr_q[f_idx][1];
        end
        if (bp.pred_taken) begin
            bp.pred_target = target_q[f_idx];
        end
    end

    // Next entry contents: train on hit, allocate on taken miss
    always_comb begin
        ent_we       = 1'b0;
        ent_valid_d  = valid_q[u_idx];
        ent_ctr_d    = ctr_q[u_idx];
        ent_tag_d    = tag_q[u_idx];
        ent_target_d = target_q[u_idx];
        if (bp.upd_valid) begin
            if (u_hit) begin
                ent_we = 1'b1;
                if (bp.upd_taken) begin
                    ent_ctr_d    = (ctr_q[u_idx] == CTR_ST) ? CTR_ST
                                                            : 2'(ctr_q[u_idx] + 2'd1);
                    ent_target_d = bp.upd_target;
                end else begin
                    ent_ctr_d    = (ctr_q[u_idx] == CTR_SNT) ? CTR_SNT
                                                             : 2'(ctr_q[u_idx] - 2'd1);
                end
            end else if (bp.upd_taken) begin
                // Taken miss replaces whatever aliased into this slot
                ent_we       = 1'b1;
                ent_valid_d  = 1'b1;
                ent_tag_d    = u_tag;
                ent_target_d = bp.upd_target;
                ent_ctr_d    = CTR_WT;
            end
        end
    end

    // Table state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                ctr_q[i]    <= CTR_WNT;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else if (ent_we) begin
            valid_q[u_idx]  <= ent_valid_d;
            ctr_q[u_idx]    <= ent_ctr_d;
            tag_q[u_idx]    <= ent_tag_d;
            target_q[u_idx] <= ent_target_d;
        end
    end

    // Direction or target disagreement with the travelling prediction
    assign mis_c = bp.upd_valid &&
                   ((bp.upd_taken != bp.upd_pred_taken) ||
                    (bp.upd_taken && bp.upd_pred_taken &&
                     (bp.upd_target != bp.upd_pred_target)));

    // Next redirect/counter values; redirect holds when no mispredict
    always_comb begin
        mispredict_d = mis_c;
        redirect_d   = redirect_q;
        branch_cnt_d = branch_cnt_q;
        mis_cnt_d    = mis_cnt_q;
        if (mis_c) begin
            redirect_d = bp.upd_taken ? bp.upd_target : (bp.upd_pc + 32'd4);
            mis_cnt_d  = mis_cnt_q + 32'd1;
        end
        if (bp.upd_valid) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
    end

    // Redirect and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            branch_cnt_q <= '0;
            mis_cnt_q    <= '0;
        end else begin
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
            branch_cnt_q <= branch_cnt_d;
            mis_cnt_q    <= mis_cnt_d;
        end
    end

    assign bp.mispredict       = mispredict_q;
    assign bp.redirect_pc      = redirect_q;
    assign bp.branch_count     = branch_cnt_q;
    assign bp.mispredict_count = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed table, reset-mid-pulse sequence, random vs model.
module tb_branch_predictor;

    localparam int N = 16;

    logic clk;
    logic rst_n;

    branch_predictor_if bus ();

    branch_predictor #(.ENTRIES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] fpc;
        bit          uv;
        logic [31:0] upc;
        bit          ut;
        logic [31:0] utgt;
        bit          upt;
        logic [31:0] uptgt;
        bit          e_hit;
        bit          e_tk;
        logic [31:0] e_tgt;
        bit          e_mis;
        logic [31:0] e_red;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model: table of entries, plain integer counters
    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;
    logic [31:0] m_red;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_ctr[i]   = 1;
        end
        m_bcnt = 0;
        m_mcnt = 0;
        m_red  = 0;
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] pc);
        return pc / (4 * N);
    endfunction

    task automatic m_lookup(input logic [31:0] pc, output bit hit, output bit tk,
                            output logic [31:0] tgt);
        int i;
        i   = m_idx(pc);
        hit = m_valid[i] && (m_tag[i] == m_tagof(pc));
        tk  = hit && (m_ctr[i] >= 2);
        tgt = tk ? m_tgt[i] : pc + 32'd4;
    endtask

    task automatic m_update(input bit uv, input logic [31:0] pc, input bit tk,
                            input logic [31:0] tgt);
        int i;
        if (!uv) return;
        m_bcnt = m_bcnt + 1;
        i = m_idx(pc);
        if (m_valid[i] && m_tag[i] == m_tagof(pc)) begin
            if (tk) begin
                m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                m_tgt[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (tk) begin
            m_valid[i] = 1;
            m_tag[i]   = m_tagof(pc);
            m_tgt[i]   = tgt;
            m_ctr[i]   = 2;
        end
    endtask

    // One cycle: lookup checked before the edge, registered outputs after it
    task automatic do_cycle(input vec_t v, input bit use_tab, input string tag);
        bit          hit, tk, mis;
        logic [31:0] tgt;
        bus.fetch_pc        = v.fpc;
        bus.upd_valid       = v.uv;
        bus.upd_pc          = v.upc;
        bus.upd_taken       = v.ut;
        bus.upd_target      = v.utgt;
        bus.upd_pred_taken  = v.upt;
        bus.upd_pred_target = v.uptgt;
        #1;
        m_lookup(v.fpc, hit, tk, tgt);
        if (use_tab) begin
            hit = v.e_hit;
            tk  = v.e_tk;
            tgt = v.e_tgt;
        end
        chk({tag, " pred_hit"},    32'(bus.pred_hit),   32'(hit));
        chk({tag, " pred_taken"},  32'(bus.pred_taken), 32'(tk));
        chk({tag, " pred_target"}, bus.pred_target,     tgt);
        mis = v.uv && ((v.ut != v.upt) || (v.ut && v.upt && v.utgt != v.uptgt));
        if (mis) begin
            m_mcnt = m_mcnt + 1;
            m_red  = v.ut ? v.utgt : v.upc + 32'd4;
        end
        @(posedge clk);
        m_update(v.uv, v.upc, v.ut, v.utgt);
        #1;
        if (use_tab) begin
            mis = v.e_mis;
            chk({tag, " redirect_pc"}, bus.redirect_pc, v.e_red);
        end else begin
            chk({tag, " redirect_pc"}, bus.redirect_pc, m_red);
        end
        chk({tag, " mispredict"},       32'(bus.mispredict), 32'(mis));
        chk({tag, " branch_count"},     bus.branch_count,     m_bcnt);
        chk({tag, " mispredict_count"}, bus.mispredict_count, m_mcnt);
    endtask

    function automatic vec_t mk(input logic [31:0] fpc, input bit uv, input logic [31:0] upc,
                                input bit ut, input logic [31:0] utgt, input bit upt,
                                input logic [31:0] uptgt, input bit e_hit, input bit e_tk,
                                input logic [31:0] e_tgt, input bit e_mis,
                                input logic [31:0] e_red);
        vec_t v;
        v.fpc = fpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
        v.upt = upt; v.uptgt = uptgt; v.e_hit = e_hit; v.e_tk = e_tk;
        v.e_tgt = e_tgt; v.e_mis = e_mis; v.e_red = e_red;
        return v;
    endfunction

    vec_t tab [18];

    initial begin
        vec_t        v;
        bit          hit, tk;
        logic [31:0] tgt;

        // fpc, uv, upc, ut, utgt, upt, uptgt | hit, tk, tgt, mis, redirect
        tab[0]  = mk(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 32'h104, 0, 32'h0);
        tab[1]  = mk(32'h100, 1, 32'h100, 1, 32'h80,  0, 32'h104, 0, 0, 32'h104, 1, 32'h80);
        tab[2]  = mk(32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80,  1, 1, 32'h80,  0, 32'h80);
        tab[3]  = mk(32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80,  1, 1, 32'h80,  0, 32'h80);
        tab[4]  = mk(32'h100, 1, 32'h100, 1, 32'h80,  1, 32'h80,  1, 1, 32'h80,  0, 32'h80);
        tab[5]  = mk(32'h100, 1, 32'h100, 0, 32'h80,  1, 32'h80,  1, 1, 32'h80,  1, 32'h104);
        tab[6]  = mk(32'h100, 1, 32'h100, 0, 32'h80,  1, 32'h80,  1, 1, 32'h80,  1, 32'h104);
        tab[7]  = mk(32'h100, 1, 32'h100, 0, 32'h80,  0, 32'h104, 1, 0, 32'h104, 0, 32'h104);
        tab[8]  = mk(32'h100, 1, 32'h100, 0, 32'h80,  0, 32'h104, 1, 0, 32'h104, 0, 32'h104);
        tab[9]  = mk(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0, 32'h104, 0, 32'h104);
        tab[10] = mk(32'h100, 1, 32'h140, 1, 32'h200, 0, 32'h144, 1, 0, 32'h104, 1, 32'h200);
        tab[11] = mk(32'h100, 1, 32'h180, 0, 32'h0,   0, 32'h184, 0, 0, 32'h104, 0, 32'h200);
        tab[12] = mk(32'h140, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 1, 32'h200, 0, 32'h200);
        tab[13] = mk(32'h180, 1, 32'h140, 1, 32'h90,  1, 32'h80,  0, 0, 32'h184, 1, 32'h90);
        tab[14] = mk(32'h140, 1, 32'h140, 0, 32'h0,   1, 32'h90,  1, 1, 32'h90,  1, 32'h144);
        tab[15] = mk(32'h140, 1, 32'h140, 0, 32'h0,   1, 32'h90,  1, 1, 32'h90,  1, 32'h144);
        tab[16] = mk(32'h140, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0, 32'h144, 0, 32'h144);
        tab[17] = mk(32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0,   0, 32'h144);

        rst_n = 1'b0;
        bus.fetch_pc = 0; bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_taken = 0;
        bus.upd_target = 0; bus.upd_pred_taken = 0; bus.upd_pred_target = 0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset mispredict",       32'(bus.mispredict), 32'h0);
        chk("reset redirect_pc",      bus.redirect_pc,      32'h0);
        chk("reset branch_count",     bus.branch_count,     32'h0);
        chk("reset mispredict_count", bus.mispredict_count, 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            do_cycle(tab[i], 1'b1, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a mispredict pulse
        v = mk(32'h140, 1, 32'h140, 1, 32'h300, 0, 32'h144, 0, 0, 0, 0, 0);
        bus.fetch_pc = v.fpc; bus.upd_valid = 1; bus.upd_pc = v.upc; bus.upd_taken = 1;
        bus.upd_target = v.utgt; bus.upd_pred_taken = 0; bus.upd_pred_target = v.uptgt;
        @(posedge clk);
        #1;
        bus.upd_valid = 0;
        chk("pulse before reset", 32'(bus.mispredict), 32'h1);
        chk("pulse redirect",     bus.redirect_pc,      32'h300);
        rst_n = 1'b0;
        #1;
        chk("midrst mispredict",       32'(bus.mispredict), 32'h0);
        chk("midrst redirect_pc",      bus.redirect_pc,      32'h0);
        chk("midrst branch_count",     bus.branch_count,     32'h0);
        chk("midrst mispredict_count", bus.mispredict_count, 32'h0);
        chk("midrst pred_hit",         32'(bus.pred_hit),   32'h0);
        chk("midrst pred_target",      bus.pred_target,      32'h144);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic over a small PC pool so aliasing and hits are frequent
        for (int n = 0; n < 400; n++) begin
            v.fpc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
            v.upc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 19) == 0) v.fpc = 32'hFFFF_FFFC;
            v.uv   = ($urandom_range(0, 3) != 0);
            v.ut   = $urandom_range(0, 1) == 1;
            v.utgt = ($urandom_range(0, 1) == 1) ? 32'h200 : (32'($urandom) & 32'hFFFF_FFFC);
            m_lookup(v.upc, hit, tk, tgt);
            v.upt   = ($urandom_range(0, 3) != 0) ? tk : ($urandom_range(0, 1) == 1);
            v.uptgt = ($urandom_range(0, 3) != 0) ? tgt : 32'h200;
            do_cycle(v, 1'b0, $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
